// File: rtl/cla_chunk_sequencer_pkg.sv
// Shared definitions for the chunked carry-lookahead adder sequencer:
// state encodings, default geometry and a width helper.
// Optional feature macro used by the top: CLA_SEQ_SUB_EN (adds a subtract input).
package cla_chunk_sequencer_pkg;

    // Default operand width and slice width.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 4;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a single-chunk build still has an index bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_chunk_sequencer_chunk_add.sv
// Combinational CHUNK-bit carry-lookahead adder slice.
// Every carry is formed directly from generate/propagate terms and ci,
// so no carry depends on a lower slice carry output.
module cla_chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci.
    always_comb begin
        logic acc;
        logic pp;
        w_c    = '0;
        w_c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            acc = w_g[i];
            pp  = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & w_g[j]);
                pp  = pp & w_p[j];
            end
            acc        = acc | (pp & ci);
            w_c[i + 1] = acc;
        end
    end

    assign s  = w_p ^ w_c[CHUNK-1:0];
    assign co = w_c[CHUNK];

endmodule

// File: rtl/cla_chunk_sequencer.sv
// Multi-cycle wide adder: one shared CHUNK-bit lookahead slice is stepped
// over the operands LSB first, with the inter-slice carry held in a register.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the consumer-side valid is held with stable data until taken.
// Optional macro CLA_SEQ_SUB_EN adds input `sub` (1 = a - b).
module cla_chunk_sequencer
    import cla_chunk_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic [1:0]       o_dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = clog2_min1(NCHUNK);

    state_t            r_state;
    state_t            w_next_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_c_out;
    logic              r_ovf;

    logic              w_accept;
    logic              w_step;
    logic              w_last;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_carry0;
    logic [CHUNK-1:0]  w_a_slice;
    logic [CHUNK-1:0]  w_b_slice;
    logic [CHUNK-1:0]  w_s;
    logic              w_co;

`ifdef CLA_SEQ_SUB_EN
    // Subtraction is a + ~b + 1; c_in is ignored while subtracting.
    assign w_b_eff  = sub ? ~b : b;
    assign w_carry0 = sub ? 1'b1 : c_in;
`else
    assign w_b_eff  = b;
    assign w_carry0 = c_in;
`endif

    // Select the operand slices addressed by the chunk index.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_a_slice = r_a[k*CHUNK +: CHUNK];
                w_b_slice = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    cla_chunk_add #(
        .CHUNK (CHUNK)
    ) u_add (
        .a  (w_a_slice),
        .b  (w_b_slice),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and step control.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = (r_idx == IDXW'(NCHUNK - 1));
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-chunk accumulation and final flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_carry0;
            r_idx   <= '0;
        end else if (w_step) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (r_idx == IDXW'(k)) begin
                    r_sum[k*CHUNK +: CHUNK] <= w_s;
                end
            end
            r_carry <= w_co;
            if (w_last) begin
                // The top chunk's MSB is the result sign.
                r_c_out <= w_co;
                r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                           (w_s[CHUNK-1] != r_a[WIDTH-1]);
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign sum         = r_sum;
    assign c_out       = r_c_out;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// Testbench for cla_chunk_sequencer at WIDTH=32, CHUNK=4: fixed vector
// table, handshake corner sequences, mid-run reset and randomized operands
// checked against an arithmetic reference model.
module tb_cla_chunk_sequencer;

    localparam int W   = 32;
    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Clock.
    always #5 clk = ~clk;

    cla_chunk_sequencer #(
        .WIDTH (32),
        .CHUNK (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .c_in        (c_in),
`ifdef CLA_SEQ_SUB_EN
        .sub         (sub),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum         (sum),
        .c_out       (c_out),
        .ovf         (ovf),
        .o_dbg_state (dbg_state)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_co;
        logic         exp_ov;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition of a, the effective b and the carry.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                         input logic do_sub, output logic [W-1:0] s, output logic co,
                         output logic ov);
        logic [W-1:0]   be;
        logic           ci;
        logic [63:0]    u;
        longint         total;
        be    = do_sub ? ~mb : mb;
        ci    = do_sub ? 1'b1 : mcin;
        u     = {32'b0, ma} + {32'b0, be} + {63'b0, ci};
        s     = u[W-1:0];
        co    = u[W];
        total = longint'($signed(ma)) + longint'($signed(be)) + longint'(ci);
        ov    = (total > 64'sd2147483647) || (total < -64'sd2147483648);
    endtask

    // Drive one operation, measure latency, check result, optionally stall
    // the consumer for `hold` cycles (with a stray in_valid pulse if asked).
    task automatic run_op(input string name, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic ocin, input logic osub, input logic [W-1:0] es,
                          input logic eco, input logic eov, input int hold, input logic pulse);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, " ready_wait"}, W'(in_ready), W'(1));
        a        = oa;
        b        = ob;
        c_in     = ocin;
`ifdef CLA_SEQ_SUB_EN
        sub      = osub;
`else
        if (osub) $display("note: subtract requested in add-only build");
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        c_in     = 1'($urandom_range(0, 1));
        t = 0;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check({name, " latency"}, W'(t), W'(LAT));
        check({name, " sum"}, sum, es);
        check({name, " c_out"}, W'(c_out), W'(eco));
        check({name, " ovf"}, W'(ovf), W'(eov));
        check({name, " in_ready_done"}, W'(in_ready), W'(0));
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 1) begin
                a        = 32'hDEAD_BEEF;
                b        = 32'h0101_0101;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check({name, " hold_valid"}, W'(out_valid), W'(1));
            check({name, " hold_sum"}, sum, es);
            check({name, " hold_in_ready"}, W'(in_ready), W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " post_valid"}, W'(out_valid), W'(0));
        check({name, " post_in_ready"}, W'(in_ready), W'(1));
        check({name, " post_sum_kept"}, sum, es);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W-1:0] es;
        logic         eco;
        logic         eov;

        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_000F, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        // Reset: asserted asynchronously between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst in_ready", W'(in_ready), W'(1));
        check("rst out_valid", W'(out_valid), W'(0));
        check("rst sum", sum, W'(0));
        check("rst c_out", W'(c_out), W'(0));
        check("rst ovf", W'(ovf), W'(0));
        check("rst state", W'(dbg_state), W'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed vectors.
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                   vecs[i].exp_sum, vecs[i].exp_co, vecs[i].exp_ov, 0, 1'b0);
        end

        // Consumer stall for 5 cycles with a stray in_valid pulse.
        run_op("stall", 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0,
               32'h0000_5555, 1'b0, 1'b0, 5, 1'b1);
        check("stall idle_state", W'(dbg_state), W'(0));

        // Reset after three RUN cycles discards the operation.
        a        = 32'hFFFF_0000;
        b        = 32'h0000_FFFF;
        c_in     = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst run_state", W'(dbg_state), W'(1));
        check("midrst partial_sum", sum & 32'h0000_0FFF, 32'h0000_0FFF);
        #2 rst_n = 1'b0;
        #1;
        check("midrst in_ready", W'(in_ready), W'(1));
        check("midrst out_valid", W'(out_valid), W'(0));
        check("midrst sum", sum, W'(0));
        check("midrst c_out", W'(c_out), W'(0));
        check("midrst ovf", W'(ovf), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
               32'h2345_6789, 1'b0, 1'b0, 0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        run_op("sub5m7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub7m5", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 0, 1'b0);
`endif

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h8000_0000;
                2: ra = 32'h7FFF_FFFF;
                default: ;
            endcase
            rc = 1'($urandom_range(0, 1));
`ifdef CLA_SEQ_SUB_EN
            begin
                logic rs;
                rs = 1'($urandom_range(0, 1));
                model(ra, rb, rc, rs, es, eco, eov);
                run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, es, eco, eov,
                       $urandom_range(0, 2), 1'b0);
            end
`else
            model(ra, rb, rc, 1'b0, es, eco, eov);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, 1'b0, es, eco, eov,
                   $urandom_range(0, 2), 1'b0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
